// File: rtl/game_controller.sv
// game_controller: cursor handling, placement sequencing and per-side scoring
// for a two-player board game. Talks to an external board memory (read and
// write ports) and to an external win checker through a start/done handshake.
module game_controller #(
  parameter int BOARD_N = 10,
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_place,
  output logic [4:0]         cursor_x,
  output logic [4:0]         cursor_y,
  output logic [1:0]         turn,
  output logic               rd_en,
  output logic [4:0]         rd_x,
  output logic [4:0]         rd_y,
  input  logic [1:0]         rd_data,
  output logic               wr_en,
  output logic [4:0]         wr_x,
  output logic [4:0]         wr_y,
  output logic [1:0]         wr_val,
  output logic               chk_start,
  output logic [4:0]         chk_x,
  output logic [4:0]         chk_y,
  output logic [1:0]         chk_turn,
  input  logic               chk_done,
  input  logic               chk_win,
  output logic [SCORE_W-1:0] score_trig,
  output logic [SCORE_W-1:0] score_circ,
  output logic [6:0]         move_count,
  output logic               illegal,
  output logic               game_over
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CHECK, S_WRITE, S_START, S_WAIT, S_UPDATE, S_OVER
  } state_t;

  localparam logic [1:0]         TURN_TRI  = 2'b01;
  localparam logic [1:0]         TURN_CIRC = 2'b10;
  localparam logic [4:0]         CUR_MAX   = 5'(BOARD_N - 1);
  localparam logic [6:0]         CELLS     = 7'(BOARD_N * BOARD_N);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  state_t             r_state;
  state_t             w_next_state;
  logic [4:0]         r_cur_x;
  logic [4:0]         r_cur_y;
  logic [4:0]         w_cur_x_nxt;
  logic [4:0]         w_cur_y_nxt;
  logic [1:0]         r_turn;
  logic [SCORE_W-1:0] r_score_trig;
  logic [SCORE_W-1:0] r_score_circ;
  logic [6:0]         r_move_count;
  logic [6:0]         w_move_inc;
  logic               r_win;
  logic               r_rd_en;
  logic               r_wr_en;
  logic               r_chk_start;
  logic               r_game_over;

  // Score counters stick at their maximum instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] res;
    if (v == SCORE_MAX) begin
      res = v;
    end else begin
      res = v + SCORE_ONE;
    end
    return res;
  endfunction

  assign w_move_inc = r_move_count + 7'd1;

  // Next-state decode for the placement sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   w_next_state = btn_place ? S_READ : S_IDLE;
      S_READ:   w_next_state = S_CHECK;
      S_CHECK:  w_next_state = (rd_data == 2'b00) ? S_WRITE : S_IDLE;
      S_WRITE:  w_next_state = S_START;
      S_START:  w_next_state = S_WAIT;
      S_WAIT:   w_next_state = chk_done ? S_UPDATE : S_WAIT;
      S_UPDATE: w_next_state = (w_move_inc == CELLS) ? S_OVER : S_IDLE;
      S_OVER:   w_next_state = S_OVER;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Cursor moves only in IDLE without a place request; one move, left first.
  always_comb begin
    w_cur_x_nxt = r_cur_x;
    w_cur_y_nxt = r_cur_y;
    if (r_state == S_IDLE && !btn_place) begin
      if (btn_left) begin
        w_cur_x_nxt = (r_cur_x == 5'd0) ? r_cur_x : r_cur_x - 5'd1;
      end else if (btn_right) begin
        w_cur_x_nxt = (r_cur_x == CUR_MAX) ? r_cur_x : r_cur_x + 5'd1;
      end else if (btn_up) begin
        w_cur_y_nxt = (r_cur_y == 5'd0) ? r_cur_y : r_cur_y - 5'd1;
      end else if (btn_down) begin
        w_cur_y_nxt = (r_cur_y == CUR_MAX) ? r_cur_y : r_cur_y + 5'd1;
      end else begin
        w_cur_x_nxt = r_cur_x;
      end
    end else begin
      w_cur_x_nxt = r_cur_x;
    end
  end

  // State and cursor registers; strobes are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cur_x     <= 5'd0;
      r_cur_y     <= 5'd0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_chk_start <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cur_x     <= w_cur_x_nxt;
      r_cur_y     <= w_cur_y_nxt;
      r_rd_en     <= (w_next_state == S_READ);
      r_wr_en     <= (w_next_state == S_WRITE);
      r_chk_start <= (w_next_state == S_START);
      r_game_over <= (w_next_state == S_OVER);
    end
  end

  // Game bookkeeping: win capture, scores, move count and side to move.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_turn       <= TURN_TRI;
      r_score_trig <= '0;
      r_score_circ <= '0;
      r_move_count <= 7'd0;
      r_win        <= 1'b0;
    end else begin
      if (r_state == S_WAIT && chk_done) begin
        r_win <= chk_win;
      end
      if (r_state == S_UPDATE) begin
        r_move_count <= w_move_inc;
        r_turn       <= (r_turn == TURN_TRI) ? TURN_CIRC : TURN_TRI;
        if (r_win && r_turn == TURN_TRI) begin
          r_score_trig <= sat_inc(r_score_trig);
        end
        if (r_win && r_turn == TURN_CIRC) begin
          r_score_circ <= sat_inc(r_score_circ);
        end
      end
    end
  end

  // Cursor and turn are frozen outside IDLE/UPDATE, so the checker request
  // fields stay stable for the whole START..WAIT window.
  assign cursor_x   = r_cur_x;
  assign cursor_y   = r_cur_y;
  assign turn       = r_turn;
  assign rd_en      = r_rd_en;
  assign rd_x       = r_cur_x;
  assign rd_y       = r_cur_y;
  assign wr_en      = r_wr_en;
  assign wr_x       = r_cur_x;
  assign wr_y       = r_cur_y;
  assign wr_val     = r_turn;
  assign chk_start  = r_chk_start;
  assign chk_x      = r_cur_x;
  assign chk_y      = r_cur_y;
  assign chk_turn   = r_turn;
  assign score_trig = r_score_trig;
  assign score_circ = r_score_circ;
  assign move_count = r_move_count;
  assign game_over  = r_game_over;
  // Occupancy is known only when read data arrives, so this flag follows it.
  assign illegal    = (r_state == S_CHECK) && (rd_data != 2'b00);

endmodule

// File: tb/tb_game_controller.sv
// Testbench for game_controller: randomized cursor/placement stimulus, a board
// memory and win-checker environment, and a scoreboard of expected strobes.
module tb_game_controller;
  localparam int N = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, btn_left, btn_right, btn_up, btn_down, btn_place;
  logic [1:0] rd_data;
  logic       chk_done, chk_win;
  logic [4:0] cursor_x, cursor_y, rd_x, rd_y, wr_x, wr_y, chk_x, chk_y;
  logic [1:0] turn, wr_val, chk_turn;
  logic       rd_en, wr_en, chk_start, illegal, game_over;
  logic [7:0] score_trig, score_circ;
  logic [6:0] move_count;
  // narrow-score twin driven by the same inputs
  logic [4:0] s_cx, s_cy, s_rx, s_ry, s_wx, s_wy, s_kx, s_ky;
  logic [1:0] s_turn, s_wv, s_kt, s_st, s_sc;
  logic       s_rd, s_wr, s_ks, s_il, s_go;
  logic [6:0] s_mc;

  game_controller #(.BOARD_N(N), .SCORE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn_left(btn_left), .btn_right(btn_right),
    .btn_up(btn_up), .btn_down(btn_down), .btn_place(btn_place),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .turn(turn),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_val(wr_val),
    .chk_start(chk_start), .chk_x(chk_x), .chk_y(chk_y), .chk_turn(chk_turn),
    .chk_done(chk_done), .chk_win(chk_win),
    .score_trig(score_trig), .score_circ(score_circ),
    .move_count(move_count), .illegal(illegal), .game_over(game_over));

  game_controller #(.BOARD_N(N), .SCORE_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .btn_left(btn_left), .btn_right(btn_right),
    .btn_up(btn_up), .btn_down(btn_down), .btn_place(btn_place),
    .cursor_x(s_cx), .cursor_y(s_cy), .turn(s_turn),
    .rd_en(s_rd), .rd_x(s_rx), .rd_y(s_ry), .rd_data(rd_data),
    .wr_en(s_wr), .wr_x(s_wx), .wr_y(s_wy), .wr_val(s_wv),
    .chk_start(s_ks), .chk_x(s_kx), .chk_y(s_ky), .chk_turn(s_kt),
    .chk_done(chk_done), .chk_win(chk_win),
    .score_trig(s_st), .score_circ(s_sc),
    .move_count(s_mc), .illegal(s_il), .game_over(s_go));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // expected strobe events: kind 0 rd, 1 illegal, 2 wr, 3 chk
  typedef struct { int kind; int cy; int x; int y; int v; } ev_t;
  ev_t evq[$];

  // reference model
  int mx, my, mturn, mmc, wins_t, wins_c;
  int mboard [N][N];

  // environment state
  logic [1:0] board [32][32];
  int  clr_cnt = 0;
  int  force_win = -1;
  int  force_delay = -1;
  int  done_count = 0;
  int  done_cyc = 0;
  logic last_win = 1'b0;

  function automatic string kname(input int k);
    case (k)
      0:       return "rd";
      1:       return "illegal";
      2:       return "wr";
      3:       return "chk";
      default: return "unknown";
    endcase
  endfunction

  function automatic int sat(input int w, input int lim);
    return (w > lim) ? lim : w;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic observe(input int k, input int x, input int y, input int v);
    checks++;
    if (evq.size() == 0 || evq[0].cy != cyc || evq[0].kind != k) begin
      errors++;
      $display("FAIL unexpected_%s: strobe at cycle %0d x=%0d y=%0d val=%0d, none required",
               kname(k), cyc, x, y, v);
    end else begin
      if (evq[0].x != x || evq[0].y != y || evq[0].v != v) begin
        errors++;
        $display("FAIL %s_fields: got x=%0d y=%0d val=%0d required x=%0d y=%0d val=%0d",
                 kname(k), x, y, v, evq[0].x, evq[0].y, evq[0].v);
      end
      void'(evq.pop_front());
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe.
  initial begin
    forever begin
      @(negedge clk);
      while (evq.size() > 0 && evq[0].cy < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_%s: required at cycle %0d, not seen by cycle %0d",
                 kname(evq[0].kind), evq[0].cy, cyc);
        void'(evq.pop_front());
      end
      if (rd_en === 1'b1)     observe(0, int'(rd_x), int'(rd_y), 0);
      if (illegal === 1'b1)   observe(1, int'(cursor_x), int'(cursor_y), 0);
      if (wr_en === 1'b1)     observe(2, int'(wr_x), int'(wr_y), int'(wr_val));
      if (chk_start === 1'b1) observe(3, int'(chk_x), int'(chk_y), int'(chk_turn));
    end
  end

  // Board memory: read data valid the cycle after rd_en; clears on request.
  initial begin
    int clr_seen;
    clr_seen = 0;
    rd_data = 2'b00;
    forever begin
      @(negedge clk);
      if (clr_seen != clr_cnt) begin
        for (int i = 0; i < 32; i++)
          for (int j = 0; j < 32; j++) board[i][j] = 2'b00;
        clr_seen = clr_cnt;
      end
      if (rd_en === 1'b1) rd_data = board[rd_x][rd_y];
      if (wr_en === 1'b1) board[wr_x][wr_y] = wr_val;
    end
  end

  // Win checker: answers each start after a delay; stray dones when idle.
  initial begin
    int d;
    logic w;
    chk_done = 1'b0;
    chk_win = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_start === 1'b1) begin
        chk_done = 1'b0;
        chk_win = 1'b0;
        d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
        repeat (d) @(negedge clk);
        @(negedge clk);
        w = (force_win >= 0) ? (force_win != 0) : 1'($urandom_range(0, 1));
        chk_done = 1'b1;
        chk_win = w;
        last_win = w;
        done_cyc = cyc;
        done_count++;
        @(negedge clk);
        chk_done = 1'b0;
        chk_win = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        chk_done = 1'b1;
        chk_win = 1'b1;
      end else begin
        chk_done = 1'b0;
        chk_win = 1'b0;
      end
    end
  end

  task automatic check_state(input string tag);
    check({tag, "_cursor_x"}, cursor_x, mx);
    check({tag, "_cursor_y"}, cursor_y, my);
    check({tag, "_turn"}, turn, mturn);
    check({tag, "_move_count"}, move_count, mmc);
    check({tag, "_score_trig"}, score_trig, sat(wins_t, 255));
    check({tag, "_score_circ"}, score_circ, sat(wins_c, 255));
    check({tag, "_score2_trig"}, s_st, sat(wins_t, 3));
    check({tag, "_score2_circ"}, s_sc, sat(wins_c, 3));
    check({tag, "_game_over"}, game_over, (mmc == N * N) ? 1 : 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_place = 1'b0;
    {btn_left, btn_right, btn_up, btn_down} = 4'b0000;
    clr_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mx = 0; my = 0; mturn = 1; mmc = 0; wins_t = 0; wins_c = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mboard[i][j] = 0;
    check_state("reset");
    check("reset_rd_en", rd_en, 0);
    check("reset_wr_en", wr_en, 0);
    check("reset_chk_start", chk_start, 0);
    check("reset_illegal", illegal, 0);
  endtask

  // b = {left, right, up, down}; first pressed button in that order wins
  task automatic press(input logic [3:0] b);
    {btn_left, btn_right, btn_up, btn_down} = b;
    if (b[3])      mx = (mx > 0) ? mx - 1 : mx;
    else if (b[2]) mx = (mx < N - 1) ? mx + 1 : mx;
    else if (b[1]) my = (my > 0) ? my - 1 : my;
    else if (b[0]) my = (my < N - 1) ? my + 1 : my;
    @(negedge clk);
    {btn_left, btn_right, btn_up, btn_down} = 4'b0000;
    check("move_cursor_x", cursor_x, mx);
    check("move_cursor_y", cursor_y, my);
  endtask

  task automatic go_to(input int tx, input int ty);
    for (int i = 0; i < 80 && (mx != tx || my != ty); i++) begin
      if ($urandom_range(0, 3) == 0) press(4'($urandom_range(1, 15)));
      else if (mx > tx) press(4'b1000);
      else if (mx < tx) press(4'b0100);
      else if (my > ty) press(4'b0010);
      else press(4'b0001);
    end
  endtask

  task automatic place(input string tag);
    int t, occ, c0, lim;
    t = cyc;
    occ = (mboard[mx][my] != 0) ? 1 : 0;
    btn_place = 1'b1;
    {btn_left, btn_right, btn_up, btn_down} = 4'($urandom_range(0, 15));
    evq.push_back('{0, t + 1, mx, my, 0});
    if (occ != 0) begin
      evq.push_back('{1, t + 2, mx, my, 0});
    end else begin
      evq.push_back('{2, t + 3, mx, my, mturn});
      evq.push_back('{3, t + 4, mx, my, mturn});
      mboard[mx][my] = mturn;
    end
    c0 = done_count;
    lim = (occ != 0) ? t + 2 : t + 4;
    while (cyc < lim) begin
      @(negedge clk);
      btn_place = 1'($urandom_range(0, 1));
      {btn_left, btn_right, btn_up, btn_down} = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    btn_place = 1'b0;
    {btn_left, btn_right, btn_up, btn_down} = 4'b0000;
    if (occ != 0) begin
      check_state({tag, "_illegal"});
      return;
    end
    for (int i = 0; i < 40 && done_count == c0; i++) @(negedge clk);
    if (done_count == c0) begin
      check({tag, "_chk_done_timeout"}, done_count, c0 + 1);
      return;
    end
    while (cyc < done_cyc + 1) @(negedge clk);
    check({tag, "_turn_before_update"}, turn, mturn);
    @(negedge clk);
    mmc++;
    if (last_win) begin
      if (mturn == 1) wins_t++;
      else wins_c++;
    end
    mturn = (mturn == 1) ? 2 : 1;
    check_state(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d, errors=%0d", cyc, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, tx, ty, k, guard;
    rst_n = 1'b1;
    btn_place = 1'b0;
    {btn_left, btn_right, btn_up, btn_down} = 4'b0000;
    repeat (2) @(negedge clk);
    do_reset();

    // right-edge clamp, then left beats down in the same cycle
    for (int i = 1; i <= 12; i++) begin
      press(4'b0100);
      check("right_pulse_x", cursor_x, (i < 9) ? i : 9);
    end
    press(4'b1001);
    check("left_beats_down_x", cursor_x, 8);
    check("left_beats_down_y", cursor_y, 0);

    // first triangle move at (3,4), no win, checker answers at t+5
    go_to(3, 4);
    force_delay = 0;
    force_win = 0;
    place("first");
    check("first_turn", turn, 2'b10);
    check("first_move_count", move_count, 1);

    // circle wins at (4,4)
    go_to(4, 4);
    force_win = 1;
    place("circ_win");
    check("circ_win_score_circ", score_circ, 1);
    check("circ_win_score_trig", score_trig, 0);

    // triangle tries the circle-occupied cell
    force_win = -1;
    force_delay = -1;
    place("occupied");
    check("occupied_move_count", move_count, 2);
    check("occupied_turn", turn, 2'b01);

    // play the board out with random targets, some of them occupied
    guard = 0;
    while (mmc < N * N && guard < 600) begin
      guard++;
      if ($urandom_range(0, 7) == 0) begin
        tx = $urandom_range(0, N - 1);
        ty = $urandom_range(0, N - 1);
      end else begin
        k = $urandom_range(0, N * N - 1 - mmc);
        tx = 0; ty = 0;
        for (int i = 0; i < N * N; i++) begin
          if (mboard[i % N][i / N] == 0) begin
            if (k == 0) begin tx = i % N; ty = i / N; end
            k--;
          end
        end
      end
      go_to(tx, ty);
      place("game");
    end
    check("full_game_over", game_over, 1);
    check("full_move_count", move_count, N * N);

    // finished game ignores everything
    for (int i = 0; i < 8; i++) begin
      btn_place = 1'b1;
      {btn_left, btn_right, btn_up, btn_down} = 4'($urandom_range(0, 15));
      @(negedge clk);
      btn_place = 1'b0;
      {btn_left, btn_right, btn_up, btn_down} = 4'b0000;
      check("over_rd_en", rd_en, 0);
      check("over_game_over", game_over, 1);
      check("over_cursor_x", cursor_x, mx);
      check("over_cursor_y", cursor_y, my);
    end

    // reset while waiting on the checker; its late answer must be ignored
    do_reset();
    force_delay = 6;
    force_win = 1;
    t = cyc;
    btn_place = 1'b1;
    evq.push_back('{0, t + 1, 0, 0, 0});
    evq.push_back('{2, t + 3, 0, 0, 1});
    evq.push_back('{3, t + 4, 0, 0, 1});
    mboard[0][0] = 1;
    @(negedge clk);
    btn_place = 1'b0;
    while (cyc < t + 6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_wait_chk_start", chk_start, 0);
    check_state("rst_wait");
    while (cyc < t + 16) @(negedge clk);
    check_state("late_done");

    // board keeps the interrupted write; a fresh move still works
    force_delay = -1;
    force_win = -1;
    place("after_rst_occupied");
    go_to(1, 0);
    place("after_rst_legal");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", evq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 SHALL have parameter BOARD_N, default 10, meaning board side length in cells.
REQ-002 SHALL have parameter SCORE_W, default 8, meaning score counter width.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports btn_left, btn_right, btn_up, btn_down  in  1 each  single-cycle cursor-move pulses.
REQ-006 SHALL have port btn_place  in  1  single-cycle place-request pulse.
REQ-007 SHALL have ports cursor_x, cursor_y  out  5 each  current cursor cell; x + right, y + down.
REQ-008 SHALL have port turn  out  2  side to move: 01 triangle, 10 circle; 00/11 never driven.
REQ-009 SHALL have ports rd_en  out  1, rd_x/rd_y  out  5 each, rd_data  in  2: board read port, data valid the cycle after rd_en.
REQ-010 SHALL have ports wr_en  out  1, wr_x/wr_y  out  5 each, wr_val  out  2: board write port, one-cycle strobe.
REQ-011 SHALL have ports chk_start  out  1, chk_x/chk_y  out  5 each, chk_turn  out  2, chk_done  in  1, chk_win  in  1: win-checker handshake.
REQ-012 SHALL have ports score_trig, score_circ  out  SCORE_W each  win counts per side.
REQ-013 SHALL have ports move_count  out  7, illegal  out  1, game_over  out  1.

Function
REQ-014 SHALL implement states IDLE, READ, CHECK, WRITE, START, WAIT, UPDATE, OVER.
REQ-015 IDLE: btn_place -> READ; else apply at most one move per cycle, priority left > right > up > down; btn_place beats all moves in the same cycle.
REQ-016 Cursor moves SHALL clamp at 0 and BOARD_N-1; no wrap-around; move at edge leaves cursor unchanged.
REQ-017 Cursor SHALL not change outside IDLE; buttons in other states are ignored, not queued.
REQ-018 READ: rd_en=1 for one cycle, rd_x/rd_y = cursor; -> CHECK.
REQ-019 CHECK: rd_data==00 -> WRITE; otherwise illegal=1 for this one cycle, -> IDLE, turn and counters unchanged.
REQ-020 WRITE: wr_en=1 one cycle, wr_x/wr_y = cursor, wr_val = turn; -> START.
REQ-021 START: chk_start=1 one cycle, chk_x/chk_y = cursor, chk_turn = turn; -> WAIT.
REQ-022 chk_x, chk_y, chk_turn SHALL hold stable from START until leaving WAIT.
REQ-023 WAIT: hold until chk_done=1, sampling chk_win that cycle; -> UPDATE. No timeout.
REQ-024 UPDATE: if sampled win, increment score of side in turn, saturating at 2^SCORE_W-1; move_count+1; turn toggles 01<->10.
REQ-025 UPDATE: new move_count == BOARD_N*BOARD_N -> OVER, else -> IDLE.
REQ-026 Placement latency: btn_place at cycle t -> wr_en at t+3, chk_start at t+4; with chk_done at t+5, new turn visible at t+7.
REQ-027 OVER: game_over=1, all strobes 0, all inputs ignored; exit only via rst_n.
REQ-028 rd_en, wr_en, chk_start, illegal SHALL be 0 in every state other than their own.
REQ-029 chk_done outside WAIT SHALL be ignored.

Reset
REQ-030 rst_n=0 at a rising edge SHALL, in any state including mid-placement, force: state IDLE, cursor (0,0), turn 01, scores 0, move_count 0, game_over 0, all strobes 0.
REQ-031 Reset SHALL not clear the external board; clearing is owned by the board block.

Verification
REQ-032 Reset, 12 btn_right pulses -> cursor_x 9 after 9th pulse, stays 9; btn_left+btn_down same cycle at (9,0) -> (8,0).
REQ-033 Empty cell (3,4), btn_place at t, chk_done=1/chk_win=0 at t+5 -> wr_en at t+3 with wr_val 01, chk_start at t+4, turn 10 and move_count 1 at t+7.
REQ-034 Place on occupied cell (rd_data=10) -> illegal=1 at t+2, no wr_en, turn and move_count unchanged.
REQ-035 chk_win=1 on circle move -> score_circ +1, score_trig unchanged; 256 wins with SCORE_W=8 -> saturates at 255.
REQ-036 100 legal placements -> game_over=1, further btn_place produces no rd_en.
REQ-037 rst_n low during WAIT -> next cycle IDLE, chk_start 0, turn 01, move_count 0; late chk_done ignored.
